// File: rtl/reaction_pkg.sv
// Shared definitions for the multi-player reaction game: state encodings,
// LFSR seed/taps, output widths and small helper functions.
package reaction_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_READY   = 3'd2,
        S_TIMING  = 3'd3,
        S_DONE    = 3'd4,
        S_ERROR   = 3'd5,
        S_TIMEOUT = 3'd6
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // x^16 + x^14 + x^13 + x^11 + 1 -> feedback from bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int MAX_TIME_DEFAULT = 9999;
    localparam int ELAPSED_W        = 14;
    localparam int WIN_W            = 4;
    localparam int ROUND_W          = 4;

    function automatic int id_width(input int n_players);
        return (n_players > 2) ? $clog2(n_players) : 1;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/multi_reaction_fsm_if.sv
// Button inputs and display/score outputs of the reaction game controller.
// master = button/test side, slave = game controller.
interface multi_reaction_fsm_if
    import reaction_pkg::*;
#(
    parameter int N_PLAYERS = 2
);
    localparam int ID_W = id_width(N_PLAYERS);

    logic                         start_btn;
    logic [N_PLAYERS-1:0]         react_btn;
    logic                         led;
    logic [2:0]                   state_out;
    logic [ELAPSED_W-1:0]         elapsed_time;
    logic [ID_W-1:0]              winner_id;
    logic                         winner_valid;
    logic                         tie;
    logic [N_PLAYERS-1:0]         false_start;
    logic                         timeout;
    logic [WIN_W*N_PLAYERS-1:0]   wins;
    logic [ROUND_W-1:0]           round_num;
    logic                         match_done;

    modport master (
        output start_btn, react_btn,
        input  led, state_out, elapsed_time, winner_id, winner_valid, tie,
               false_start, timeout, wins, round_num, match_done
    );

    modport slave (
        input  start_btn, react_btn,
        output led, state_out, elapsed_time, winner_id, winner_valid, tie,
               false_start, timeout, wins, round_num, match_done
    );

endinterface

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts 0..TICK_DIV-1 and flags the wrap cycle as a tick.
// A clear restarts the count so the first tick lands a full period later.
module ms_tick_gen #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/multi_reaction_fsm.sv
// N-player reaction-time game controller: random hold-off, LED timing, winner
// detection with tie/false-start/timeout handling, and best-of-ROUNDS scoring.
module multi_reaction_fsm
    import reaction_pkg::*;
#(
    parameter int N_PLAYERS    = 2,
    parameter int TICK_DIV     = 1000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int SPAN_LOG2    = 11,
    parameter int MAX_TIME     = MAX_TIME_DEFAULT,
    parameter int ROUNDS       = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    multi_reaction_fsm_if.slave   game
);
    localparam int ID_W     = id_width(N_PLAYERS);
    localparam int DLY_NEED = $clog2(MIN_DELAY_MS + (1 << SPAN_LOG2));
    localparam int DLY_W    = (DLY_NEED > SPAN_LOG2 + 1) ? DLY_NEED : SPAN_LOG2 + 1;

    localparam logic [ELAPSED_W-1:0] MAX_T        = ELAPSED_W'(MAX_TIME);
    localparam logic [ROUND_W-1:0]   ROUND_TARGET = ROUND_W'(ROUNDS);
    localparam logic [DLY_W-1:0]     MIN_DLY      = DLY_W'(MIN_DELAY_MS);

    state_t                         state, state_n;
    logic                           start_prev;
    logic [N_PLAYERS-1:0]           react_prev;
    logic                           start_press;
    logic [N_PLAYERS-1:0]           react_press;
    logic [15:0]                    lfsr;

    logic [DLY_W-1:0]               delay, delay_n;
    logic [ELAPSED_W-1:0]           elapsed, elapsed_n;
    logic [ID_W-1:0]                winner, winner_n;
    logic                           tie_q, tie_n;
    logic [N_PLAYERS-1:0]           false_q, false_n;
    logic [WIN_W*N_PLAYERS-1:0]     wins_q, wins_n;
    logic [ROUND_W-1:0]             round_q, round_n, round_inc;
    logic                           match_q, match_n;

    logic [ID_W-1:0]                first_idx;
    logic                           multi_press;
    logic                           tick, tick_clear;

    ms_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (tick_clear),
        .tick  (tick)
    );

    // Button history and free-running LFSR; a held button produces one press only.
    always_ff @(posedge clk) begin
        if (reset) begin
            start_prev <= 1'b0;
            react_prev <= '0;
            lfsr       <= LFSR_SEED;
        end else begin
            start_prev <= game.start_btn;
            react_prev <= game.react_btn;
            lfsr       <= lfsr_next(lfsr);
        end
    end

    assign start_press = game.start_btn & ~start_prev;
    assign react_press = game.react_btn & ~react_prev;
    assign round_inc   = (round_q == '1) ? round_q : round_q + ROUND_W'(1);
    assign multi_press = ($countones(react_press) > 1);

    // Lowest-index pressing player wins, so scan from the top down.
    always_comb begin
        first_idx = '0;
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (react_press[i]) begin
                first_idx = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            delay   <= '0;
            elapsed <= '0;
            winner  <= '0;
            tie_q   <= 1'b0;
            false_q <= '0;
            wins_q  <= '0;
            round_q <= '0;
            match_q <= 1'b0;
        end else begin
            state   <= state_n;
            delay   <= delay_n;
            elapsed <= elapsed_n;
            winner  <= winner_n;
            tie_q   <= tie_n;
            false_q <= false_n;
            wins_q  <= wins_n;
            round_q <= round_n;
            match_q <= match_n;
        end
    end

    always_comb begin
        state_n    = state;
        delay_n    = delay;
        elapsed_n  = elapsed;
        winner_n   = winner;
        tie_n      = tie_q;
        false_n    = false_q;
        wins_n     = wins_q;
        round_n    = round_q;
        match_n    = match_q;
        tick_clear = 1'b0;

        case (state)
            S_IDLE: begin
                if (start_press) begin
                    state_n    = S_WAIT;
                    tick_clear = 1'b1;
                    delay_n    = MIN_DLY + DLY_W'(lfsr[SPAN_LOG2-1:0]);
                    elapsed_n  = '0;
                    false_n    = '0;
                    tie_n      = 1'b0;
                    if (match_q) begin
                        wins_n  = '0;
                        round_n = '0;
                        match_n = 1'b0;
                    end
                end
            end

            // A press in the same cycle the hold-off expires is still a false start.
            S_WAIT: begin
                if (|react_press) begin
                    state_n = S_ERROR;
                    false_n = react_press;
                    round_n = round_inc;
                    match_n = match_q | (round_inc == ROUND_TARGET);
                end else if (delay == '0) begin
                    state_n = S_READY;
                end else if (tick) begin
                    delay_n = delay - DLY_W'(1);
                end
            end

            S_READY: begin
                state_n    = S_TIMING;
                tick_clear = 1'b1;
                elapsed_n  = '0;
            end

            // A press beats the timeout when both land on the same cycle; elapsed
            // is not advanced on the press cycle.
            S_TIMING: begin
                if (|react_press) begin
                    state_n  = S_DONE;
                    winner_n = first_idx;
                    tie_n    = multi_press;
                    round_n  = round_inc;
                    match_n  = match_q | (round_inc == ROUND_TARGET);
                    for (int i = 0; i < N_PLAYERS; i++) begin
                        if (first_idx == ID_W'(i) && wins_q[WIN_W*i +: WIN_W] != '1) begin
                            wins_n[WIN_W*i +: WIN_W] = wins_q[WIN_W*i +: WIN_W] + WIN_W'(1);
                        end
                    end
                end else if (elapsed >= MAX_T) begin
                    state_n = S_TIMEOUT;
                    round_n = round_inc;
                    match_n = match_q | (round_inc == ROUND_TARGET);
                end else if (tick) begin
                    elapsed_n = elapsed + ELAPSED_W'(1);
                end
            end

            S_DONE, S_ERROR, S_TIMEOUT: begin
                if (start_press) begin
                    state_n = S_IDLE;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign game.led          = (state == S_READY) || (state == S_TIMING);
    assign game.state_out    = state;
    assign game.elapsed_time = elapsed;
    assign game.winner_id    = winner;
    assign game.winner_valid = (state == S_DONE);
    assign game.tie          = tie_q && (state == S_DONE);
    assign game.false_start  = (state == S_ERROR) ? false_q : '0;
    assign game.timeout      = (state == S_TIMEOUT);
    assign game.wins         = wins_q;
    assign game.round_num    = round_q;
    assign game.match_done   = match_q;

endmodule

// File: tb/tb_multi_reaction_fsm.sv
// Directed bench for multi_reaction_fsm with a 3-player, fast-tick configuration.
// Inputs change and outputs are sampled 1 time unit after each rising clock edge.
module tb_multi_reaction_fsm;

    localparam logic [15:0] ST_IDLE    = 16'd0;
    localparam logic [15:0] ST_WAIT    = 16'd1;
    localparam logic [15:0] ST_READY   = 16'd2;
    localparam logic [15:0] ST_TIMING  = 16'd3;
    localparam logic [15:0] ST_DONE    = 16'd4;
    localparam logic [15:0] ST_ERROR   = 16'd5;
    localparam logic [15:0] ST_TIMEOUT = 16'd6;

    logic clk = 1'b0;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;
    int   holdoff;
    int   budget;
    logic holdoff_ok;

    multi_reaction_fsm_if #(.N_PLAYERS(3)) game ();

    multi_reaction_fsm #(
        .N_PLAYERS    (3),
        .TICK_DIV     (4),
        .MIN_DELAY_MS (5),
        .SPAN_LOG2    (2),
        .MAX_TIME     (20),
        .ROUNDS       (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .game  (game)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic start, input logic [2:0] react);
        game.start_btn = start;
        game.react_btn = react;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic waitLed();
        int k = 0;
        while (game.led !== 1'b1 && k < 100) begin
            applyStimulus(1'b0, 3'b000);
            k++;
        end
        checkOutput("led_on_reached", {15'd0, game.led}, 16'd1);
    endtask

    task automatic waitElapsed(input logic [13:0] target);
        int k = 0;
        while (!(game.state_out == 3'd3 && game.elapsed_time == target) && k < 200) begin
            applyStimulus(1'b0, 3'b000);
            k++;
        end
        checkOutput("elapsed_reached", {2'b00, game.elapsed_time}, {2'b00, target});
    endtask

    // From DONE/ERROR/TIMEOUT: back to IDLE, release, then start the next round.
    task automatic newRound();
        applyStimulus(1'b1, 3'b000);
        applyStimulus(1'b0, 3'b000);
        applyStimulus(1'b1, 3'b000);
        applyStimulus(1'b0, 3'b000);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 3'b000);
        applyStimulus(1'b0, 3'b000);
        reset = 1'b0;

        checkOutput("rst_state",        {13'd0, game.state_out},    ST_IDLE);
        checkOutput("rst_led",          {15'd0, game.led},          16'd0);
        checkOutput("rst_elapsed",      {2'd0, game.elapsed_time},  16'd0);
        checkOutput("rst_winner_valid", {15'd0, game.winner_valid}, 16'd0);
        checkOutput("rst_wins",         {4'd0, game.wins},          16'd0);
        checkOutput("rst_round",        {12'd0, game.round_num},    16'd0);

        // Round 1: P1 reacts once elapsed shows 7 ms.
        applyStimulus(1'b1, 3'b000);
        checkOutput("r1_wait", {13'd0, game.state_out}, ST_WAIT);
        applyStimulus(1'b0, 3'b000);
        waitLed();
        checkOutput("r1_ready", {13'd0, game.state_out}, ST_READY);
        waitElapsed(14'd7);
        applyStimulus(1'b0, 3'b010);
        checkOutput("r1_state",    {13'd0, game.state_out},    ST_DONE);
        checkOutput("r1_valid",    {15'd0, game.winner_valid}, 16'd1);
        checkOutput("r1_winner",   {14'd0, game.winner_id},    16'd1);
        checkOutput("r1_elapsed",  {2'd0, game.elapsed_time},  16'd7);
        checkOutput("r1_tie",      {15'd0, game.tie},          16'd0);
        checkOutput("r1_wins",     {4'd0, game.wins},          16'h0010);
        checkOutput("r1_round",    {12'd0, game.round_num},    16'd1);
        checkOutput("r1_led",      {15'd0, game.led},          16'd0);
        applyStimulus(1'b0, 3'b010);
        checkOutput("r1_held_elapsed", {2'd0, game.elapsed_time}, 16'd7);

        // Round 2: P2 presses during the hold-off.
        newRound();
        applyStimulus(1'b0, 3'b000);
        applyStimulus(1'b0, 3'b000);
        checkOutput("r2_wait",   {13'd0, game.state_out}, ST_WAIT);
        checkOutput("r2_led_lo", {15'd0, game.led},       16'd0);
        applyStimulus(1'b0, 3'b100);
        checkOutput("r2_state",  {13'd0, game.state_out},  ST_ERROR);
        checkOutput("r2_false",  {13'd0, game.false_start}, 16'b100);
        checkOutput("r2_led",    {15'd0, game.led},         16'd0);
        checkOutput("r2_round",  {12'd0, game.round_num},   16'd2);
        checkOutput("r2_valid",  {15'd0, game.winner_valid}, 16'd0);

        // Round 3: P0 and P2 together -> P0 wins with tie, match complete.
        newRound();
        waitLed();
        applyStimulus(1'b0, 3'b000);
        applyStimulus(1'b0, 3'b000);
        applyStimulus(1'b0, 3'b101);
        checkOutput("r3_state",  {13'd0, game.state_out},  ST_DONE);
        checkOutput("r3_winner", {14'd0, game.winner_id},  16'd0);
        checkOutput("r3_tie",    {15'd0, game.tie},        16'd1);
        checkOutput("r3_elapsed",{2'd0, game.elapsed_time},16'd0);
        checkOutput("r3_wins",   {4'd0, game.wins},        16'h0011);
        checkOutput("r3_round",  {12'd0, game.round_num},  16'd3);
        checkOutput("r3_match",  {15'd0, game.match_done}, 16'd1);

        // Next match: scores persist in IDLE, clear on the start press.
        applyStimulus(1'b1, 3'b000);
        checkOutput("m2_idle",       {13'd0, game.state_out},  ST_IDLE);
        checkOutput("m2_idle_match", {15'd0, game.match_done}, 16'd1);
        checkOutput("m2_idle_wins",  {4'd0, game.wins},        16'h0011);
        applyStimulus(1'b0, 3'b000);
        applyStimulus(1'b1, 3'b000);
        checkOutput("m2_wins_clr",  {4'd0, game.wins},        16'd0);
        checkOutput("m2_round_clr", {12'd0, game.round_num},  16'd0);
        checkOutput("m2_match_clr", {15'd0, game.match_done}, 16'd0);
        applyStimulus(1'b0, 3'b000);

        // Nobody reacts -> TIMEOUT at the MAX_TIME of 20 ms.
        waitLed();
        budget = 0;
        while (game.state_out != 3'd6 && budget < 200) begin
            applyStimulus(1'b0, 3'b000);
            budget++;
        end
        checkOutput("to_state",   {13'd0, game.state_out},   ST_TIMEOUT);
        checkOutput("to_elapsed", {2'd0, game.elapsed_time}, 16'd20);
        checkOutput("to_flag",    {15'd0, game.timeout},     16'd1);
        checkOutput("to_led",     {15'd0, game.led},         16'd0);
        checkOutput("to_round",   {12'd0, game.round_num},   16'd1);

        // Press on the very cycle elapsed shows 20 -> press wins over timeout.
        newRound();
        waitLed();
        waitElapsed(14'd20);
        checkOutput("edge_timing", {13'd0, game.state_out}, ST_TIMING);
        applyStimulus(1'b0, 3'b001);
        checkOutput("edge_state",   {13'd0, game.state_out},   ST_DONE);
        checkOutput("edge_elapsed", {2'd0, game.elapsed_time}, 16'd20);
        checkOutput("edge_winner",  {14'd0, game.winner_id},   16'd0);
        checkOutput("edge_timeout", {15'd0, game.timeout},     16'd0);
        checkOutput("edge_wins",    {4'd0, game.wins},         16'h0001);
        checkOutput("edge_round",   {12'd0, game.round_num},   16'd2);

        // P1 held from IDLE through the hold-off: never counts as a press.
        applyStimulus(1'b1, 3'b000);
        applyStimulus(1'b0, 3'b010);
        applyStimulus(1'b1, 3'b010);
        holdoff = 1;
        while (game.led !== 1'b1 && holdoff < 100) begin
            applyStimulus(1'b0, 3'b010);
            holdoff++;
        end
        // LED comes on 4*delay+2 cycles after the start edge, delay in 5..8 ms.
        holdoff_ok = (holdoff >= 22) && (holdoff <= 34) && ((holdoff - 2) % 4 == 0);
        checkOutput("hold_holdoff", {15'd0, holdoff_ok},      16'd1);
        checkOutput("hold_ready",   {13'd0, game.state_out},  ST_READY);
        applyStimulus(1'b0, 3'b010);
        applyStimulus(1'b0, 3'b010);
        applyStimulus(1'b0, 3'b010);
        checkOutput("hold_timing",  {13'd0, game.state_out},    ST_TIMING);
        checkOutput("hold_valid",   {15'd0, game.winner_valid}, 16'd0);

        // Reset in the middle of TIMING.
        reset = 1'b1;
        applyStimulus(1'b0, 3'b010);
        reset = 1'b0;
        checkOutput("mid_rst_state",   {13'd0, game.state_out},   ST_IDLE);
        checkOutput("mid_rst_led",     {15'd0, game.led},         16'd0);
        checkOutput("mid_rst_elapsed", {2'd0, game.elapsed_time}, 16'd0);
        checkOutput("mid_rst_wins",    {4'd0, game.wins},         16'd0);
        checkOutput("mid_rst_round",   {12'd0, game.round_num},   16'd0);
        checkOutput("mid_rst_false",   {13'd0, game.false_start}, 16'd0);
        checkOutput("mid_rst_match",   {15'd0, game.match_done},  16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
